// File: rtl/bird_motion_pkg.sv
// Shared encodings and default geometry for the multi-bird motion controller.
package bird_motion_pkg;

  typedef enum logic [1:0] {
    B_IDLE = 2'b00,
    B_FLY  = 2'b01,
    B_FALL = 2'b10,
    B_ESC  = 2'b11
  } bird_st_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_NEXT
  } seq_st_e;

  localparam int DEF_NUM_BIRDS = 2;
  localparam int DEF_XW        = 8;
  localparam int DEF_YW        = 7;
  localparam int DEF_X_MAX     = 150;
  localparam int DEF_Y_FLOOR   = 100;
  localparam int DEF_STEP      = 2;
  localparam int DEF_FALL_STEP = 4;
  localparam int DEF_X_START   = 40;
  localparam int DEF_X_SPACING = 60;

endpackage

// File: rtl/bird_motion_ctrl_if.sv
// Request/done handshake between the motion controller and the shared pixel drawer.
interface bird_motion_ctrl_if #(
  parameter int XW = 8,
  parameter int YW = 7
);
  logic          draw_req;
  logic          draw_erase;
  logic [2:0]    draw_id;
  logic [XW-1:0] draw_x;
  logic [YW-1:0] draw_y;
  logic          draw_done;

  modport master (output draw_req, draw_erase, draw_id, draw_x, draw_y, input draw_done);
  modport slave  (input draw_req, draw_erase, draw_id, draw_x, draw_y, output draw_done);
endinterface

// File: rtl/bird_step.sv
// One bird's next position/state for a frame: sticky shot/escape first, then the step.
module bird_step
  import bird_motion_pkg::*;
#(
  parameter int XW        = DEF_XW,
  parameter int YW        = DEF_YW,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_FLOOR   = DEF_Y_FLOOR,
  parameter int STEP      = DEF_STEP,
  parameter int FALL_STEP = DEF_FALL_STEP
) (
  input  bird_st_e      st,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          rand_x,
  input  logic          rand_y,
  input  logic          shot_l,
  input  logic          esc_l,
  output bird_st_e      nst,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny
);
  typedef logic [XW:0] xe_t;
  typedef logic [YW:0] ye_t;

  // One extra bit of headroom so the bounce compare never sees a wrapped sum.
  localparam xe_t XS = xe_t'(STEP);
  localparam xe_t XL = xe_t'(X_MAX);
  localparam ye_t YS = ye_t'(STEP);
  localparam ye_t YF = ye_t'(FALL_STEP);
  localparam ye_t YL = ye_t'(Y_FLOOR);

  bird_st_e st_eff;
  xe_t      xe, nxe;
  ye_t      ye, nye;

  always_comb begin
    st_eff = st;
    if (st == B_FLY && shot_l)     st_eff = B_FALL;
    else if (st == B_FLY && esc_l) st_eff = B_ESC;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    nxe = xe;
    nye = ye;
    nst = st_eff;
    case (st_eff)
      B_FLY: begin
        if (rand_x) nxe = (xe + XS > XL) ? xe - XS : xe + XS;
        else        nxe = (xe < XS)      ? xe + XS : xe - XS;
        if (rand_y) nye = (ye + YS > YL) ? ye - YS : ye + YS;
        else        nye = (ye < YS)      ? ye + YS : ye - YS;
      end
      B_FALL: begin
        nye = ye + YF;
        if (nye >= YL) begin
          nye = YL;
          nst = B_IDLE;
        end
      end
      B_ESC: begin
        if (ye < YS) begin
          nye = '0;
          nst = B_IDLE;
        end else begin
          nye = ye - YS;
        end
      end
      default: ;
    endcase
    nx = nxe[XW-1:0];
    ny = nye[YW-1:0];
  end
endmodule

// File: rtl/bird_motion_ctrl.sv
// Multi-bird motion controller: per frame tick, erase/move/draw each live bird
// in index order through the shared drawer handshake.
module bird_motion_ctrl
  import bird_motion_pkg::*;
#(
  parameter int NUM_BIRDS = DEF_NUM_BIRDS,
  parameter int XW        = DEF_XW,
  parameter int YW        = DEF_YW,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_FLOOR   = DEF_Y_FLOOR,
  parameter int STEP      = DEF_STEP,
  parameter int FALL_STEP = DEF_FALL_STEP,
  parameter int X_START   = DEF_X_START,
  parameter int X_SPACING = DEF_X_SPACING
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    spawn,
  input  logic [NUM_BIRDS-1:0]    shot,
  input  logic                    escape,
  input  logic [NUM_BIRDS-1:0]    rand_x,
  input  logic [NUM_BIRDS-1:0]    rand_y,
  bird_motion_ctrl_if.master      drw,
  output logic [NUM_BIRDS*XW-1:0] bird_x,
  output logic [NUM_BIRDS*YW-1:0] bird_y,
  output logic [2*NUM_BIRDS-1:0]  bird_state,
  output logic                    busy,
  output logic                    all_done
);
  localparam int IW = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;

  logic [XW-1:0]        bx  [NUM_BIRDS];
  logic [YW-1:0]        by  [NUM_BIRDS];
  bird_st_e             bst [NUM_BIRDS];
  logic [NUM_BIRDS-1:0] shot_lat, esc_lat, live;

  seq_st_e       st_q, st_d;
  logic [IW-1:0] cur_q, cur_d;
  logic          tick_q, tick_edge, pend, go;
  logic [IW:0]   first_hit, next_hit;

  bird_st_e      step_st;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;

  // {found, index} of the lowest live bird at or above 'from'.
  function automatic logic [IW:0] find_live(input logic [NUM_BIRDS-1:0] m, input int from);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_BIRDS - 1; i >= 0; i--)
      if (i >= from && m[i]) r = {1'b1, IW'(i)};
    return r;
  endfunction

  for (genvar i = 0; i < NUM_BIRDS; i++) begin : g_flat
    assign bird_x[i*XW +: XW]  = bx[i];
    assign bird_y[i*YW +: YW]  = by[i];
    assign bird_state[2*i +: 2] = bst[i];
    assign live[i]             = (bst[i] != B_IDLE);
  end

  assign busy      = (st_q != S_IDLE);
  assign all_done  = ~|live;
  assign go        = (tick_edge | pend) & ~spawn;
  assign first_hit = find_live(live, 0);
  assign next_hit  = find_live(live, int'(cur_q) + 1);

  bird_step #(
    .XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_FLOOR(Y_FLOOR),
    .STEP(STEP), .FALL_STEP(FALL_STEP)
  ) u_step (
    .st    (bst[cur_q]),
    .x     (bx[cur_q]),
    .y     (by[cur_q]),
    .rand_x(rand_x[cur_q]),
    .rand_y(rand_y[cur_q]),
    .shot_l(shot_lat[cur_q] | shot[cur_q]),
    .esc_l (esc_lat[cur_q] | escape),
    .nst   (step_st),
    .nx    (step_x),
    .ny    (step_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_IDLE;
      cur_q <= '0;
    end else begin
      st_q  <= st_d;
      cur_q <= cur_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    case (st_q)
      S_IDLE: if (go && first_hit[IW]) begin
        st_d  = S_ERASE;
        cur_d = first_hit[IW-1:0];
      end
      S_ERASE: if (drw.draw_done) st_d = S_MOVE;
      S_MOVE:  st_d = (step_st == B_IDLE) ? S_NEXT : S_DRAW;
      S_DRAW:  if (drw.draw_done) st_d = S_NEXT;
      S_NEXT: begin
        if (next_hit[IW]) begin
          st_d  = S_ERASE;
          cur_d = next_hit[IW-1:0];
        end else begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    drw.draw_req   = 1'b0;
    drw.draw_erase = 1'b0;
    drw.draw_id    = '0;
    drw.draw_x     = '0;
    drw.draw_y     = '0;
    if (st_q == S_ERASE || st_q == S_DRAW) begin
      drw.draw_req   = 1'b1;
      drw.draw_erase = (st_q == S_ERASE);
      drw.draw_id    = 3'(cur_q);
      drw.draw_x     = bx[cur_q];
      drw.draw_y     = by[cur_q];
    end
  end

  // A tick edge seen while a pass is running is remembered once; a spawn in idle defers it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      tick_edge <= 1'b0;
      pend      <= 1'b0;
    end else begin
      tick_q    <= tick;
      tick_edge <= tick & ~tick_q;
      if (st_q != S_IDLE) pend <= pend | tick_edge;
      else                pend <= (pend | tick_edge) & spawn;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BIRDS; i++) begin
      if (reset) begin
        bx[i]       <= '0;
        by[i]       <= '0;
        bst[i]      <= B_IDLE;
        shot_lat[i] <= 1'b0;
        esc_lat[i]  <= 1'b0;
      end else if (spawn && st_q == S_IDLE) begin
        bx[i]       <= XW'(X_START + i * X_SPACING);
        by[i]       <= YW'(Y_FLOOR);
        bst[i]      <= B_FLY;
        shot_lat[i] <= 1'b0;
        esc_lat[i]  <= 1'b0;
      end else begin
        if (shot[i] && bst[i] == B_FLY) shot_lat[i] <= 1'b1;
        if (escape && bst[i] == B_FLY && !shot[i] && !shot_lat[i]) esc_lat[i] <= 1'b1;
        if (st_q == S_MOVE && cur_q == IW'(i)) begin
          bx[i]       <= step_x;
          by[i]       <= step_y;
          bst[i]      <= step_st;
          shot_lat[i] <= 1'b0;
          esc_lat[i]  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Parametrised multi-bird motion controller; next generation of the single-sprite movement FSM. Owns position and life state for NUM_BIRDS birds, advances each live bird once per frame tick (random flight, shot-fall, escape-climb), and sequences erase/draw requests for every bird to the shared pixel drawer over a req/done handshake. Sits between the game-round logic (spawn, shot, escape, RNG) and the VGA drawer.

## Interface
- NUM_BIRDS, 2, number of bird channels (1..8)
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- X_MAX, 150, largest legal x
- Y_FLOOR, 100, ground line y; spawn and fall-landing row
- STEP, 2, flight/escape step per tick, both axes
- FALL_STEP, 4, downward step per tick while falling
- X_START, 40, spawn x of bird 0
- X_SPACING, 60, spawn x increment per bird index
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  frame-rate level clock; rising edge detected internally
- spawn  in  1  pulse: launch all birds
- shot  in  NUM_BIRDS  per-bird hit pulse
- escape  in  1  pulse: all flying birds flee
- rand_x, rand_y  in  NUM_BIRDS each  per-bird direction bits (1 = +x / +y)
- draw_req  out  1  drawer request
- draw_erase  out  1  1 = erase sprite, 0 = draw sprite
- draw_id  out  3  bird index of request
- draw_x, draw_y  out  XW, YW  sprite origin
- draw_done  in  1  drawer completion pulse
- bird_x, bird_y  out  NUM_BIRDS*XW, NUM_BIRDS*YW  flat positions, bird i at [i*W +: W]
- bird_state  out  2*NUM_BIRDS  per bird: 00 IDLE, 01 FLY, 10 FALL, 11 ESC
- busy  out  1  sequencer not in S_IDLE
- all_done  out  1  every bird IDLE

## Operation
- Sequencer states: S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_NEXT.
- S_IDLE: on tick rising edge (or pending tick) with any bird non-IDLE, select lowest non-IDLE index, go S_ERASE; if all IDLE, edge discarded.
- S_ERASE: draw_req=1, draw_erase=1, current position; on draw_done go S_MOVE.
- S_MOVE (1 cycle): apply sticky shot/escape flags, then step:
  - FLY: x ± STEP by rand_x, y ± STEP by rand_y; bounce: if x+STEP > X_MAX use −STEP, if x < STEP use +STEP; y likewise against Y_FLOOR and 0.
  - FALL: y += FALL_STEP; if result ≥ Y_FLOOR, y = Y_FLOOR, state → IDLE.
  - ESC: if y < STEP, y = 0, state → IDLE; else y −= STEP; x unchanged.
- S_DRAW: skipped if bird became IDLE in S_MOVE; else draw_req=1, draw_erase=0, new position; on draw_done go S_NEXT.
- S_NEXT: next higher non-IDLE index → S_ERASE, else S_IDLE.
- shot[i]: honoured only while bird i is FLY; latched, becomes FALL at its next S_MOVE. shot to IDLE/FALL/ESC bird ignored.
- escape: latches ESC for every FLY bird not holding a shot latch; shot wins on same bird.
- spawn: accepted only when busy=0; all birds FLY at x = X_START + i*X_SPACING, y = Y_FLOOR; latches cleared. Dropped when busy=1.
- Arithmetic: steps computed at XW+1/YW+1 bits, no wrap-around.

## Timing
- Reset: all outputs 0, positions 0, every bird IDLE, latches and pending tick cleared, all_done=1. Reset mid-handshake abandons request; draw_done after reset ignored.
- Tick edge detect: 1 cycle latency. Edge while busy sets one-deep pending flag; further edges dropped.
- draw_req, draw_erase, draw_id, draw_x, draw_y stable from assertion until draw_done sampled high; draw_req low the cycle after. draw_done while draw_req=0 ignored.
- bird_x/bird_y/bird_state update the cycle after S_MOVE.
- Per-bird cost: 1 (S_MOVE) + 1 (S_NEXT) cycles plus two drawer handshakes.

## Structure
- bird_motion_pkg: bird state encodings, sequencer state enum, default parameter constants.
- Sub-module bird_step: combinational next-position/next-state for one bird (state, x, y, rand bits, latches → new x, y, state); instantiated once, muxed by current index.

## Test plan
- Reset then spawn -> bird_state=0101, bird_x={100,40}, bird_y={100,100}, all_done=0.
- Tick, rand_x=11, rand_y=00, bird 0 at (40,100) -> erase req (40,100), then draw req (42,98); then bird 1 erase (100,100), draw (102,98).
- Bird 0 at (149,50), rand_x=1 -> moves to (147,·) (bounce), never exceeds X_MAX.
- shot=01 with escape same cycle -> bird 0 FALL, bird 1 ESC; falling from y=98 -> 100 and IDLE with no draw request.
- Tick edges while busy: two edges -> exactly one extra pass; spawn while busy dropped; reset during S_DRAW -> draw_req=0 next cycle, all_done=1.
